// File: rtl/counter_readout.sv
`default_nettype none
// ============================================================================
// Module      : counter_readout
// Description : Sequences one readout run of four external 8-bit counter ICs.
//               It issues a reset request to the counter-pin controller, then
//               a programmable number of advance requests. It waits for the
//               counters to settle and captures all four (synchronized)
//               counter outputs in one cycle. It then streams the captured
//               values as channel-tagged words over a valid/ready handshake.
// Ports       : clk, rst            - clock (rising edge), sync active-high reset
//               start, num_pulses   - run request (IDLE only) and advance count
//               counter_q_1..4      - asynchronous counter IC outputs
//               reset_counter,
//               advance_counter     - registered requests to pin controller
//               data_out, data_chan,
//               data_valid,
//               data_ready          - output word stream, one word per handshake
//               busy, done          - run in progress / one-cycle completion
// Revision    : 1.0 - initial release
// ============================================================================
module counter_readout #(
  parameter int PULSE_CYCLES  = 4,  // request high time, must be >= 1
  parameter int GAP_CYCLES    = 4,  // low time after each request, must be >= 1
  parameter int SETTLE_CYCLES = 8   // wait before sampling, must be >= 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [15:0] num_pulses,
  input  logic [7:0]  counter_q_1,
  input  logic [7:0]  counter_q_2,
  input  logic [7:0]  counter_q_3,
  input  logic [7:0]  counter_q_4,
  output logic        reset_counter,
  output logic        advance_counter,
  output logic [7:0]  data_out,
  output logic [1:0]  data_chan,
  output logic        data_valid,
  input  logic        data_ready,
  output logic        busy,
  output logic        done
);

  // Phase timers count down to zero, so each phase loads "length - 1".
  localparam logic [15:0] PULSE_LOAD  = 16'(PULSE_CYCLES - 1);
  localparam logic [15:0] GAP_LOAD    = 16'(GAP_CYCLES - 1);
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE      = 4'd0,
    RST_PULSE = 4'd1,
    RST_GAP   = 4'd2,
    ADV_PULSE = 4'd3,
    ADV_GAP   = 4'd4,
    SETTLE    = 4'd5,
    CAPTURE   = 4'd6,
    STREAM    = 4'd7,
    FINISH    = 4'd8
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [15:0] timer;
  logic [15:0] timer_next;
  logic [15:0] pulses_left;
  logic [15:0] pulses_left_next;
  logic [1:0]  chan;
  logic [1:0]  chan_next;

  logic [7:0]  q_in  [4];
  logic [7:0]  sync1 [4];
  logic [7:0]  sync2 [4];
  logic [7:0]  cap   [4];

  assign q_in[0] = counter_q_1;
  assign q_in[1] = counter_q_2;
  assign q_in[2] = counter_q_3;
  assign q_in[3] = counter_q_4;

  // Two-flop synchronizer per counter IC; the counters are clocked by the
  // pin controller, not by clk.
  for (genvar g = 0; g < 4; g++) begin : g_sync
    always_ff @(posedge clk) begin
      if (rst) begin
        sync1[g] <= 8'd0;
        sync2[g] <= 8'd0;
      end else begin
        sync1[g] <= q_in[g];
        sync2[g] <= sync1[g];
      end
    end
  end

  // State, timers and registered request outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= IDLE;
      timer           <= 16'd0;
      pulses_left     <= 16'd0;
      chan            <= 2'd0;
      reset_counter   <= 1'b0;
      advance_counter <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        cap[i] <= 8'd0;
      end
    end else begin
      state       <= state_next;
      timer       <= timer_next;
      pulses_left <= pulses_left_next;
      chan        <= chan_next;
      // Requests are decoded from the next state so they are true flops that
      // line up exactly with the pulse states; mutual exclusion follows from
      // the state encoding.
      reset_counter   <= (state_next == RST_PULSE);
      advance_counter <= (state_next == ADV_PULSE);
      if (state == CAPTURE) begin
        for (int i = 0; i < 4; i++) begin
          cap[i] <= sync2[i];
        end
      end
    end
  end

  // Next-state logic.
  always_comb begin
    state_next       = state;
    timer_next       = timer;
    pulses_left_next = pulses_left;
    chan_next        = chan;

    case (state)
      IDLE: begin
        if (start) begin
          state_next       = RST_PULSE;
          timer_next       = PULSE_LOAD;
          pulses_left_next = num_pulses;
        end
      end

      RST_PULSE: begin
        if (timer == 16'd0) begin
          state_next = RST_GAP;
          timer_next = GAP_LOAD;
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      // Both gaps share the same exit decision: another advance if any
      // remain, otherwise settle. Testing for zero (not decrementing first)
      // keeps 0xFFFF from wrapping.
      RST_GAP, ADV_GAP: begin
        if (timer == 16'd0) begin
          if (pulses_left != 16'd0) begin
            state_next = ADV_PULSE;
            timer_next = PULSE_LOAD;
          end else begin
            state_next = SETTLE;
            timer_next = SETTLE_LOAD;
          end
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      ADV_PULSE: begin
        if (timer == 16'd0) begin
          state_next       = ADV_GAP;
          timer_next       = GAP_LOAD;
          pulses_left_next = pulses_left - 16'd1;
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      SETTLE: begin
        if (timer == 16'd0) begin
          state_next = CAPTURE;
        end else begin
          timer_next = timer - 16'd1;
        end
      end

      CAPTURE: begin
        state_next = STREAM;
        chan_next  = 2'd0;
      end

      STREAM: begin
        if (data_ready) begin
          if (chan == 2'd3) begin
            state_next = FINISH;
            chan_next  = 2'd0;
          end else begin
            chan_next = chan + 2'd1;
          end
        end
      end

      FINISH: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Output word is forced to zero outside STREAM so stale captures never
  // appear on the bus while idle.
  assign data_valid = (state == STREAM);
  assign data_out   = data_valid ? cap[chan] : 8'd0;
  assign data_chan  = data_valid ? chan : 2'd0;
  assign busy       = (state != IDLE);
  assign done       = (state == FINISH);

endmodule
`default_nettype wire

// File: tb/tb_counter_readout.sv
`default_nettype none
// ============================================================================
// Module      : tb_counter_readout
// Description : Directed self-checking bench for counter_readout.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_counter_readout;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] num_pulses;
  logic [7:0]  counter_q_1;
  logic [7:0]  counter_q_2;
  logic [7:0]  counter_q_3;
  logic [7:0]  counter_q_4;
  logic        reset_counter;
  logic        advance_counter;
  logic [7:0]  data_out;
  logic [1:0]  data_chan;
  logic        data_valid;
  logic        data_ready;
  logic        busy;
  logic        done;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  counter_readout dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .num_pulses      (num_pulses),
    .counter_q_1     (counter_q_1),
    .counter_q_2     (counter_q_2),
    .counter_q_3     (counter_q_3),
    .counter_q_4     (counter_q_4),
    .reset_counter   (reset_counter),
    .advance_counter (advance_counter),
    .data_out        (data_out),
    .data_chan       (data_chan),
    .data_valid      (data_valid),
    .data_ready      (data_ready),
    .busy            (busy),
    .done            (done)
  );

  // All driving and sampling happens on the falling edge.
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_q(input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] c, input logic [7:0] d);
    counter_q_1 = a;
    counter_q_2 = b;
    counter_q_3 = c;
    counter_q_4 = d;
  endtask

  // Called at a falling edge; returns at the falling edge of cycle 1
  // (cycle 0 is the cycle in which start is high).
  task automatic start_run(input logic [15:0] n);
    num_pulses = n;
    start      = 1'b1;
    tick();
    start      = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({reset_counter, advance_counter, data_valid, busy, done} !== 5'b0 ||
        data_out !== 8'h00 || data_chan !== 2'd0) begin
      errors++;
      $display("FAIL reset_outputs: rc=%b ac=%b v=%b busy=%b done=%b out=%h chan=%0d, required all 0",
               reset_counter, advance_counter, data_valid, busy, done, data_out, data_chan);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle: busy=%b, required 0", busy);
    end
  endtask

  // NUM_PULSES=3, default timing, words 0x11..0x44 with ready held high.
  task automatic test_timing();
    logic [7:0] exp_q [4];
    logic exp_rc, exp_ac, exp_v, exp_dn, exp_bz;
    exp_q[0] = 8'h11; exp_q[1] = 8'h22; exp_q[2] = 8'h33; exp_q[3] = 8'h44;
    set_q(8'h11, 8'h22, 8'h33, 8'h44);
    data_ready = 1'b1;
    start_run(16'd3);
    for (int k = 1; k <= 47; k++) begin
      exp_rc = (k >= 1 && k <= 4);
      exp_ac = (k >= 9 && k <= 12) || (k >= 17 && k <= 20) || (k >= 25 && k <= 28);
      exp_v  = (k >= 42 && k <= 45);
      exp_dn = (k == 46);
      exp_bz = (k <= 46);
      checks++;
      if (reset_counter !== exp_rc || advance_counter !== exp_ac) begin
        errors++;
        $display("FAIL timing_req cycle %0d: rc=%b ac=%b, required rc=%b ac=%b",
                 k, reset_counter, advance_counter, exp_rc, exp_ac);
      end
      checks++;
      if (data_valid !== exp_v || done !== exp_dn || busy !== exp_bz) begin
        errors++;
        $display("FAIL timing_status cycle %0d: v=%b done=%b busy=%b, required v=%b done=%b busy=%b",
                 k, data_valid, done, busy, exp_v, exp_dn, exp_bz);
      end
      if (exp_v) begin
        checks++;
        if (data_chan !== 2'(k - 42) || data_out !== exp_q[k - 42]) begin
          errors++;
          $display("FAIL timing_word cycle %0d: chan=%0d out=%h, required chan=%0d out=%h",
                   k, data_chan, data_out, k - 42, exp_q[k - 42]);
        end
      end
      if (k < 47) tick();
    end
  endtask

  // NUM_PULSES=0: settle follows the reset gap directly.
  task automatic test_zero_pulses();
    logic [7:0] exp_q [4];
    logic exp_rc, exp_v, exp_dn;
    exp_q[0] = 8'hA1; exp_q[1] = 8'hB2; exp_q[2] = 8'hC3; exp_q[3] = 8'hD4;
    set_q(8'hA1, 8'hB2, 8'hC3, 8'hD4);
    data_ready = 1'b1;
    tick();
    start_run(16'd0);
    for (int k = 1; k <= 23; k++) begin
      exp_rc = (k >= 1 && k <= 4);
      exp_v  = (k >= 18 && k <= 21);
      exp_dn = (k == 22);
      checks++;
      if (reset_counter !== exp_rc || advance_counter !== 1'b0 ||
          data_valid !== exp_v || done !== exp_dn) begin
        errors++;
        $display("FAIL zero_pulses cycle %0d: rc=%b ac=%b v=%b done=%b, required rc=%b ac=0 v=%b done=%b",
                 k, reset_counter, advance_counter, data_valid, done, exp_rc, exp_v, exp_dn);
      end
      if (exp_v) begin
        checks++;
        if (data_chan !== 2'(k - 18) || data_out !== exp_q[k - 18]) begin
          errors++;
          $display("FAIL zero_word cycle %0d: chan=%0d out=%h, required chan=%0d out=%h",
                   k, data_chan, data_out, k - 18, exp_q[k - 18]);
        end
      end
      if (k < 23) tick();
    end
  endtask

  // Ready toggles every cycle; inputs change after capture.
  task automatic test_ready_toggle();
    logic [7:0] exp_q [4];
    int  guard;
    int  got;
    logic r;
    exp_q[0] = 8'h5A; exp_q[1] = 8'h6B; exp_q[2] = 8'h7C; exp_q[3] = 8'h8D;
    set_q(8'h5A, 8'h6B, 8'h7C, 8'h8D);
    data_ready = 1'b0;
    tick();
    start_run(16'd1);
    guard = 0;
    while (data_valid !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (guard + 1 != 26) begin
      errors++;
      $display("FAIL toggle_stream_start: first valid cycle=%0d, required 26", guard + 1);
    end
    set_q(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    got = 0;
    r   = 1'b0;
    guard = 0;
    while (got < 4 && guard < 20) begin
      checks++;
      if (data_valid !== 1'b1 || data_chan !== 2'(got) || data_out !== exp_q[got]) begin
        errors++;
        $display("FAIL toggle_word step %0d: v=%b chan=%0d out=%h, required v=1 chan=%0d out=%h",
                 guard, data_valid, data_chan, data_out, got, exp_q[got]);
      end
      r = ~r;
      data_ready = r;
      if (data_valid === 1'b1 && r) got++;
      tick();
      guard++;
    end
    checks++;
    if (got != 4 || done !== 1'b1 || data_valid !== 1'b0) begin
      errors++;
      $display("FAIL toggle_done: words=%0d done=%b v=%b, required words=4 done=1 v=0",
               got, done, data_valid);
    end
    tick();
    checks++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL toggle_idle: done=%b busy=%b, required 0 0", done, busy);
    end
    data_ready = 1'b1;
  endtask

  // Reset during the second advance pulse, then a complete fresh run.
  task automatic test_rst_mid_run();
    int cyc;
    int adv_edges;
    int nwords;
    int busy_cycles;
    logic prev_adv;
    logic [9:0] words [4];
    set_q(8'h11, 8'h22, 8'h33, 8'h44);
    data_ready = 1'b1;
    tick();
    start_run(16'd3);
    repeat (17) tick();
    checks++;
    if (advance_counter !== 1'b1) begin
      errors++;
      $display("FAIL midrst_pre: ac=%b at cycle 18, required 1", advance_counter);
    end
    rst = 1'b1;
    tick();
    checks++;
    if (advance_counter !== 1'b0 || reset_counter !== 1'b0 || busy !== 1'b0 ||
        data_valid !== 1'b0 || done !== 1'b0) begin
      errors++;
      $display("FAIL midrst_after: ac=%b rc=%b busy=%b v=%b done=%b, required all 0",
               advance_counter, reset_counter, busy, data_valid, done);
    end
    rst = 1'b0;
    busy_cycles = 0;
    for (int i = 0; i < 30; i++) begin
      tick();
      if (busy !== 1'b0 || advance_counter !== 1'b0) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 0) begin
      errors++;
      $display("FAIL midrst_no_resume: active cycles=%0d, required 0", busy_cycles);
    end
    start_run(16'd2);
    cyc = 1;
    adv_edges = 0;
    nwords = 0;
    prev_adv = 1'b0;
    while (done !== 1'b1 && cyc < 60) begin
      if (advance_counter === 1'b1 && !prev_adv) adv_edges++;
      prev_adv = advance_counter;
      if (data_valid === 1'b1) begin
        if (nwords < 4) words[nwords] = {data_chan, data_out};
        nwords++;
      end
      tick();
      cyc++;
    end
    checks++;
    if (cyc != 38 || adv_edges != 2 || nwords != 4) begin
      errors++;
      $display("FAIL rerun_shape: done cycle=%0d advances=%0d words=%0d, required 38 2 4",
               cyc, adv_edges, nwords);
    end
    checks++;
    if (nwords == 4 && (words[0] !== {2'd0, 8'h11} || words[1] !== {2'd1, 8'h22} ||
                        words[2] !== {2'd2, 8'h33} || words[3] !== {2'd3, 8'h44})) begin
      errors++;
      $display("FAIL rerun_words: %h %h %h %h, required 011 122 233 344",
               words[0], words[1], words[2], words[3]);
    end
    tick();
  endtask

  // START during STREAM must not queue another run.
  task automatic test_start_ignored();
    int guard;
    int busy_cycles;
    set_q(8'h01, 8'h02, 8'h03, 8'h04);
    data_ready = 1'b0;
    start_run(16'd0);
    guard = 0;
    while (data_valid !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    checks++;
    if (data_valid !== 1'b1 || data_chan !== 2'd0 || data_out !== 8'h01) begin
      errors++;
      $display("FAIL ignore_hold: v=%b chan=%0d out=%h, required v=1 chan=0 out=01",
               data_valid, data_chan, data_out);
    end
    data_ready = 1'b1;
    guard = 0;
    while (done !== 1'b1 && guard < 10) begin
      tick();
      guard++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_done: done=%b after %0d cycles, required 1", done, guard);
    end
    busy_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (busy !== 1'b0) busy_cycles++;
    end
    checks++;
    if (busy_cycles != 0) begin
      errors++;
      $display("FAIL ignore_no_run: busy cycles=%0d, required 0", busy_cycles);
    end
    start_run(16'd0);
    checks++;
    if (busy !== 1'b1 || reset_counter !== 1'b1) begin
      errors++;
      $display("FAIL ignore_fresh_start: busy=%b rc=%b, required 1 1", busy, reset_counter);
    end
    guard = 0;
    while (done !== 1'b1 && guard < 40) begin
      tick();
      guard++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL ignore_fresh_done: done=%b, required 1", done);
    end
    tick();
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num_pulses = 16'd0;
    data_ready = 1'b0;
    set_q(8'h00, 8'h00, 8'h00, 8'h00);
    tick();
    test_reset();
    test_timing();
    test_zero_pulses();
    test_ready_toggle();
    test_rst_mid_run();
    test_start_ignored();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
